// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch_ctrl : PC sequencer + fetch queue with redirect flush and zero-word halt
// Revision: 1.0
// ---------------------------------------------------------------------------
module inst_fetch_ctrl #(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = '0,
   parameter int           DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fetch_en,
   output logic [N-1:0] imem_addr,
   input  logic [N-1:0] imem_inst,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_pc,
   output logic         out_valid,
   output logic [N-1:0] out_inst,
   output logic [N-1:0] out_pc,
   input  logic         out_ready,
   output logic         halted,
   output logic [2:0]   q_count
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t       state;
   logic [N-1:0] pc;
   logic [N-1:0] q_inst   [DEPTH];
   logic [N-1:0] q_pc     [DEPTH];
   logic [N-1:0] nxt_inst [DEPTH];
   logic [N-1:0] nxt_pc   [DEPTH];

   logic         pop;
   logic         room;
   logic         attempt;
   logic         push;
   logic         go_halt;
   logic [2:0]   wr_idx;

   assign imem_addr = pc;
   assign out_valid = (q_count != 3'd0);
   assign out_inst  = q_inst[0];
   assign out_pc    = q_pc[0];

   // Shift-down queue: entry 0 is always the head, vacated slots refill with zero
   always_comb begin
      pop     = out_valid & out_ready;
      room    = (q_count < 3'(DEPTH)) | pop;
      attempt = (state == RUN) & fetch_en & ~redirect_valid & room;
      push    = attempt & (imem_inst != '0);
      go_halt = attempt & (imem_inst == '0);
      wr_idx  = q_count - {2'b00, pop};
      for (int i = 0; i < DEPTH; i++) begin
         nxt_inst[i] = q_inst[i];
         nxt_pc[i]   = q_pc[i];
         if (pop) begin
            if (i == DEPTH - 1) begin
               nxt_inst[i] = '0;
               nxt_pc[i]   = '0;
            end else begin
               nxt_inst[i] = q_inst[(i + 1) % DEPTH];
               nxt_pc[i]   = q_pc[(i + 1) % DEPTH];
            end
         end
         if (push && (wr_idx == 3'(i))) begin
            nxt_inst[i] = imem_inst;
            nxt_pc[i]   = pc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         halted  <= 1'b0;
         pc      <= {RESET_PC[N-1:2], 2'b00};
         q_count <= 3'd0;
         for (int i = 0; i < DEPTH; i++) begin
            q_inst[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else if (redirect_valid) begin
         // Flush wins over any concurrent pop; nothing is fetched this cycle
         state   <= RUN;
         halted  <= 1'b0;
         pc      <= {redirect_pc[N-1:2], 2'b00};
         q_count <= 3'd0;
         for (int i = 0; i < DEPTH; i++) begin
            q_inst[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            q_inst[i] <= nxt_inst[i];
            q_pc[i]   <= nxt_pc[i];
         end
         q_count <= q_count + {2'b00, push} - {2'b00, pop};
         if (push) begin
            pc <= pc + N'(4);
         end
         if (go_halt) begin
            state  <= HALT;
            halted <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// Testbench for inst_fetch_ctrl: directed scenarios plus random traffic
// against a queue-based reference model and a decoupled scoreboard monitor.
module tb_inst_fetch_ctrl;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_valid;
   logic        halted;
   logic [2:0]  q_count;

   logic [31:0] mem [64];
   int          checks = 0;
   int          errors = 0;
   int          delivered = 0;

   // Reference model state: expected stream (pc,inst) plus occupancy/pc/halt
   logic [63:0] sb [$];
   logic [31:0] mpc = '0;
   int          mcount = 0;
   bit          mhalt = 1'b0;

   inst_fetch_ctrl #(.N(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .imem_addr(imem_addr), .imem_inst(imem_inst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
      .out_ready(out_ready), .halted(halted), .q_count(q_count)
   );

   always #5 clk = ~clk;

   assign imem_inst = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT against the model mid-cycle, pops on accepted output
   always @(negedge clk) begin
      if (rst_n) begin
         chk("imem_addr", imem_addr, mpc);
         chk("halted", 32'(halted), 32'(mhalt));
         chk("q_count", 32'(q_count), 32'(mcount));
         chk("out_valid", 32'(out_valid), 32'(mcount != 0));
         if (out_valid && sb.size() != 0) begin
            chk("head_pc", out_pc, sb[0][63:32]);
            chk("head_inst", out_inst, sb[0][31:0]);
            if (out_ready && !redirect_valid) begin
               void'(sb.pop_front());
               delivered++;
            end
         end else if (!out_valid) begin
            chk("empty_inst", out_inst, 32'h0);
            chk("empty_pc", out_pc, 32'h0);
         end
      end
   end

   task automatic model_reset();
      mpc = '0;
      mcount = 0;
      mhalt = 1'b0;
      sb.delete();
   endtask

   // Predicts the effect of the coming clock edge from the current inputs
   task automatic model_step();
      logic [31:0] w;
      bit          pop;
      bit          room;
      if (!rst_n) return;
      pop = (mcount > 0) && out_ready;
      if (redirect_valid) begin
         sb.delete();
         mcount = 0;
         mpc = redirect_pc & ~32'h3;
         mhalt = 1'b0;
         return;
      end
      room = (mcount < DEPTH) || pop;
      if (pop) mcount--;
      if (!mhalt && fetch_en && room) begin
         w = (mpc < 32'd256) ? mem[mpc[7:2]] : 32'h0;
         if (w != 32'h0) begin
            sb.push_back({mpc, w});
            mcount++;
            mpc = mpc + 32'd4;
         end else begin
            mhalt = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      redirect_valid = 1'b0;
      fetch_en = 1'b0;
      out_ready = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] prog [6];
      prog[0] = 32'h00000013; prog[1] = 32'h00500513; prog[2] = 32'h00400793;
      prog[3] = 32'h40F50533; prog[4] = 32'h00A7F833; prog[5] = 32'h00A7F033;
      for (int i = 0; i < 64; i++) begin
         if (i < 6)       mem[i] = prog[i];
         else if (i == 6) mem[i] = 32'h0;
         else             mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
      end

      // Reset state
      model_reset();
      cycle();
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_count", 32'(q_count), 32'h0);
      rst_n = 1'b1;

      // Straight-line stream until the zero word at 0x18
      fetch_en = 1'b1;
      out_ready = 1'b1;
      delivered = 0;
      for (int i = 0; i < 20 && !halted; i++) cycle();
      chk("stream_halted", 32'(halted), 32'h1);
      chk("stream_addr", imem_addr, 32'h18);
      chk("stream_count", 32'(delivered), 32'd6);

      // Back-pressure fills the queue, then drains without a gap
      do_reset();
      fetch_en = 1'b1;
      out_ready = 1'b0;
      repeat (4) cycle();
      chk("full_count", 32'(q_count), 32'd2);
      chk("full_addr", imem_addr, 32'h8);
      chk("full_inst", out_inst, 32'h00000013);
      cycle();
      chk("full_stable", out_inst, 32'h00000013);
      delivered = 0;
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("drain_count", 32'(delivered), 32'd3);

      // Redirect after two fetches, low PC bits ignored
      do_reset();
      fetch_en = 1'b1;
      out_ready = 1'b1;
      repeat (2) cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000000D;
      cycle();
      redirect_valid = 1'b0;
      chk("redir_count", 32'(q_count), 32'h0);
      chk("redir_addr", imem_addr, 32'hC);
      cycle();
      chk("redir_inst", out_inst, 32'h40F50533);
      chk("redir_pc", out_pc, 32'hC);

      // Redirect out of HALT
      for (int i = 0; i < 20 && !halted; i++) cycle();
      chk("halt_addr", imem_addr, 32'h18);
      redirect_valid = 1'b1;
      redirect_pc = 32'h4;
      cycle();
      redirect_valid = 1'b0;
      chk("resume_halted", 32'(halted), 32'h0);
      cycle();
      chk("resume_inst", out_inst, 32'h00500513);

      // Asynchronous reset with a full queue
      do_reset();
      fetch_en = 1'b1;
      out_ready = 1'b0;
      repeat (3) cycle();
      chk("prereset_count", 32'(q_count), 32'd2);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_valid", 32'(out_valid), 32'h0);
      chk("async_addr", imem_addr, 32'h0);
      chk("async_count", 32'(q_count), 32'h0);
      cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      cycle();
      chk("restart_inst", out_inst, 32'h00000013);
      chk("restart_pc", out_pc, 32'h0);

      // Random traffic
      do_reset();
      repeat (3000) begin
         fetch_en = ($urandom_range(0, 99) < 85);
         out_ready = ($urandom_range(0, 99) < 70);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc = {22'h0, 8'($urandom_range(0, 70)), 2'(($urandom_range(0, 3)))};
         cycle();
      end
      redirect_valid = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
